wb_port_arbiter: RTL and testbench

Shares the register file's single write port between several writeback requesters: ALU, load unit and multi-cycle mul/div. Each requester offers one write per cycle on a valid/ready handshake; the block grants one per cycle in round-robin order. It registers the winner and drives the register file's `we`/`wr_address`/`wr_value`. An optional forwarding path returns the in-flight write to the register file read ports, so dependent reads see it one cycle early.

---
 rtl/wb_arb_pkg.sv | 26 ++
 rtl/wb_port_arbiter_rr_picker.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared constants and helpers for the writeback port arbiter.
//            Holds the data/address widths, default requester count,
//            wait-counter width and saturation value, and the
//            rotate-priority index helper used by rr_picker.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int              c_XLEN         = 32;
    localparam int              c_AW           = 5;
    localparam int              c_NUM_REQ      = 3;
    localparam int              c_WAIT_CNT_W   = 4;
    localparam logic [3:0]      c_WAIT_CNT_MAX = 4'd15;

    // Position 'offset' in the rotated priority order that starts at 'base'.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin picker. Searches i_valid starting at
//            i_ptr, wrapping modulo N; the first set bit wins.
// Ports    : i_valid [N]  - request vector
//            i_ptr   [PW] - index with highest priority this cycle
//            o_grant [N]  - one-hot grant (zero when nothing valid)
//            o_idx   [PW] - encoded index of the winner
//            o_any        - a winner exists
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_j;

    // Walk the priority order from lowest to highest priority so the last
    // hit written is the highest-priority valid requester.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = PW'(rr_index(int'(i_ptr), k, N));
            if (i_valid[w_j]) begin
                o_idx = w_j;
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between NUM_REQ writeback
//            requesters with round-robin grants, registers the winning
//            write onto we/wr_address/wr_value, tracks per-requester wait
//            time, and optionally forwards the in-flight write to the read
//            ports.
// Config   : WB_ARB_FORWARD_EN - when defined, rs1/rs2_value take wr_value
//            on an address match while we=1; otherwise pure pass-through.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_addr/req_data in, req_ready out (one-hot grant)
//            wb_hold in - blocks all grants
//            we/wr_address/wr_value out - registered write port
//            rs1/rs2_address, rs1/rs2_rf in; rs1/rs2_value out
//            grant_cnt_overflow out - sticky wait-counter saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ,
    parameter int XLEN    = c_XLEN,
    parameter int AW      = c_AW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wb_hold,
    output logic                    we,
    output logic [AW-1:0]           wr_address,
    output logic [XLEN-1:0]         wr_value,
    input  logic [AW-1:0]           rs1_address,
    input  logic [AW-1:0]           rs2_address,
    input  logic [XLEN-1:0]         rs1_rf,
    input  logic [XLEN-1:0]         rs2_rf,
    output logic [XLEN-1:0]         rs1_value,
    output logic [XLEN-1:0]         rs2_value,
    output logic                    grant_cnt_overflow
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]           r_rr_ptr;
    logic                    r_we;
    logic [AW-1:0]           r_wr_address;
    logic [XLEN-1:0]         r_wr_value;
    logic                    r_overflow;
    logic [c_WAIT_CNT_W-1:0] r_wait_cnt [NUM_REQ];

    logic [NUM_REQ-1:0]      w_elig;
    logic [NUM_REQ-1:0]      w_grant;
    logic [PW-1:0]           w_idx;
    logic                    w_xfer;
    logic [AW-1:0]           w_sel_addr;
    logic [XLEN-1:0]         w_sel_data;
    logic [PW-1:0]           w_ptr_next;
    logic                    w_any_sat;

    // Hold masks the request vector so no grant can be issued while stalled.
    assign w_elig = wb_hold ? '0 : req_valid;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_picker (
        .i_valid (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_xfer)
    );

    assign req_ready  = w_grant;
    assign w_sel_addr = req_addr[w_idx*AW +: AW];
    assign w_sel_data = req_data[w_idx*XLEN +: XLEN];
    assign w_ptr_next = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // Output stage: x0 writes complete the handshake but never raise we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_we         <= 1'b0;
            r_wr_address <= '0;
            r_wr_value   <= '0;
        end else if (w_xfer) begin
            r_rr_ptr     <= w_ptr_next;
            r_we         <= (w_sel_addr != '0);
            r_wr_address <= w_sel_addr;
            r_wr_value   <= w_sel_data;
        end else begin
            r_we         <= 1'b0;
        end
    end

    // Wait counters count cycles a valid requester was passed over while
    // the pipeline was free to grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (req_valid[i] && !wb_hold &&
                             (r_wait_cnt[i] != c_WAIT_CNT_MAX)) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_any_sat = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_wait_cnt[i] == c_WAIT_CNT_MAX) begin
                w_any_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_any_sat) begin
            r_overflow <= 1'b1;
        end
    end

    assign we                 = r_we;
    assign wr_address         = r_wr_address;
    assign wr_value           = r_wr_value;
    assign grant_cnt_overflow = r_overflow;

`ifdef WB_ARB_FORWARD_EN
    assign rs1_value = (r_we && (r_wr_address == rs1_address)) ? r_wr_value : rs1_rf;
    assign rs2_value = (r_we && (r_wr_address == rs2_address)) ? r_wr_value : rs2_rf;
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^{rs1_address, rs2_address};
    assign rs1_value = rs1_rf;
    assign rs2_value = rs2_rf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter: reset state,
//            round-robin order, x0 writes, same-address ordering, stall
//            behaviour, wait-counter overflow, forwarding and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*AW-1:0]      req_addr = '0;
    logic [N*XLEN-1:0]    req_data = '0;
    logic [N-1:0]         req_ready;
    logic                 wb_hold = 1'b0;
    logic                 we;
    logic [AW-1:0]        wr_address;
    logic [XLEN-1:0]      wr_value;
    logic [AW-1:0]        rs1_address = '0;
    logic [AW-1:0]        rs2_address = '0;
    logic [XLEN-1:0]      rs1_rf = '0;
    logic [XLEN-1:0]      rs2_rf = '0;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic                 grant_cnt_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .AW(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .wb_hold            (wb_hold),
        .we                 (we),
        .wr_address         (wr_address),
        .wr_value           (wr_value),
        .rs1_address        (rs1_address),
        .rs2_address        (rs2_address),
        .rs1_rf             (rs1_rf),
        .rs2_rf             (rs2_rf),
        .rs1_value          (rs1_value),
        .rs2_value          (rs2_value),
        .grant_cnt_overflow (grant_cnt_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*AW +: AW]     = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        tick();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
        n_checks++; if (wr_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", wr_address); end
        n_checks++; if (wr_value !== '0) begin n_fail++; $display("FAIL reset_value: got %h want 0", wr_value); end
        n_checks++; if (grant_cnt_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", grant_cnt_overflow); end
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [XLEN-1:0] dv [3];
        logic [N-1:0]    exp_rdy;
        dv[0] = 32'hAAAA_0001; dv[1] = 32'hBBBB_0002; dv[2] = 32'hCCCC_0003;
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), dv[i]);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = N'(1) << (c % 3);
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
            tick();
            n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL rr_we[%0d]: got %b want 1", c, we); end
            n_checks++; if (wr_address !== AW'(c % 3 + 1)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %0d want %0d", c, wr_address, c % 3 + 1); end
            n_checks++; if (wr_value !== dv[c % 3]) begin n_fail++; $display("FAIL rr_value[%0d]: got %h want %h", c, wr_value, dv[c % 3]); end
        end
        req_valid = '0;
        tick();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rr_idle_we: got %b want 0", we); end
        n_checks++; if (wr_value !== 32'hCCCC_0003) begin n_fail++; $display("FAIL rr_hold_value: got %h want cccc0003", wr_value); end
    endtask

    task automatic test_x0_write();
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b010;
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL x0_ready: got %b want 010", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b want 0", we); end
    endtask

    task automatic test_same_addr();
        logic [XLEN-1:0] x5;
        x5 = '0;
        set_req(0, 5'd5, 32'h11);
        set_req(2, 5'd5, 32'h22);
        req_valid = 3'b101;
        #1;
        n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL same_ready0: got %b want 100", req_ready); end
        tick();
        req_valid = 3'b001;
        if (we && wr_address == 5'd5) x5 = wr_value;
        n_checks++; if (wr_value !== 32'h22 || we !== 1'b1) begin n_fail++; $display("FAIL same_first: got we=%b %h want we=1 22", we, wr_value); end
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL same_ready1: got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        if (we && wr_address == 5'd5) x5 = wr_value;
        n_checks++; if (x5 !== 32'h11) begin n_fail++; $display("FAIL same_final_x5: got %h want 11", x5); end
    endtask

    task automatic test_hold();
        set_req(0, 5'd9, 32'h99);
        req_valid = 3'b001;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL hold_pre_ready: got %b want 001", req_ready); end
        tick();
        set_req(0, 5'd10, 32'h1010);
        wb_hold = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL hold_ready_first: got %b want 000", req_ready); end
        n_checks++; if (we !== 1'b1 || wr_address !== 5'd9) begin n_fail++; $display("FAIL hold_inflight: got we=%b addr=%0d want we=1 addr=9", we, wr_address); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++; if (req_ready !== 3'b000 || we !== 1'b0) begin n_fail++; $display("FAIL hold_cycle[%0d]: got ready=%b we=%b want 000 0", c, req_ready, we); end
        end
        n_checks++; if (dut.r_wait_cnt[0] !== 4'd0) begin n_fail++; $display("FAIL hold_cnt: got %0d want 0", dut.r_wait_cnt[0]); end
        n_checks++; if (grant_cnt_overflow !== 1'b0) begin n_fail++; $display("FAIL hold_ovf: got %b want 0", grant_cnt_overflow); end
        wb_hold = 1'b0;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL hold_release_ready: got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (we !== 1'b1 || wr_address !== 5'd10) begin n_fail++; $display("FAIL hold_release_wr: got we=%b addr=%0d want 1 10", we, wr_address); end
    endtask

    task automatic test_starve_overflow();
        set_req(0, 5'd1, 32'h1);
        set_req(2, 5'd2, 32'h2);
        force dut.r_rr_ptr = 2'd0;
        req_valid = 3'b101;
        for (int c = 1; c <= 16; c++) begin
            #1;
            n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL starve_ready[%0d]: got %b want 001", c, req_ready); end
            tick();
            if (c == 15) begin
                n_checks++; if (grant_cnt_overflow !== 1'b0) begin n_fail++; $display("FAIL starve_ovf_early: got %b want 0", grant_cnt_overflow); end
            end
        end
        n_checks++; if (grant_cnt_overflow !== 1'b1) begin n_fail++; $display("FAIL starve_ovf_set: got %b want 1", grant_cnt_overflow); end
        release dut.r_rr_ptr;
        req_valid = 3'b100;
        #1;
        n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL starve_grant2: got %b want 100", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (dut.r_wait_cnt[2] !== 4'd0) begin n_fail++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.r_wait_cnt[2]); end
        tick();
        tick();
        n_checks++; if (grant_cnt_overflow !== 1'b1) begin n_fail++; $display("FAIL starve_ovf_sticky: got %b want 1", grant_cnt_overflow); end
    endtask

    task automatic test_forward_and_reset();
        logic [XLEN-1:0] exp_rs1;
        set_req(0, 5'd7, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        rs1_address = 5'd7;  rs1_rf = 32'h0;
        rs2_address = 5'd3;  rs2_rf = 32'h1234;
        #1;
`ifdef WB_ARB_FORWARD_EN
        exp_rs1 = 32'hDEAD_BEEF;
`else
        exp_rs1 = 32'h0;
`endif
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL fwd_we: got %b want 1", we); end
        n_checks++; if (rs1_value !== exp_rs1) begin n_fail++; $display("FAIL fwd_rs1: got %h want %h", rs1_value, exp_rs1); end
        n_checks++; if (rs2_value !== 32'h1234) begin n_fail++; $display("FAIL fwd_rs2_nomatch: got %h want 1234", rs2_value); end
        reset = 1'b1;
        #1;
        n_checks++; if (we !== 1'b0 || wr_address !== '0 || wr_value !== '0) begin n_fail++; $display("FAIL async_reset: got we=%b addr=%0d val=%h want 0 0 0", we, wr_address, wr_value); end
        n_checks++; if (grant_cnt_overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_ovf: got %b want 0", grant_cnt_overflow); end
        n_checks++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL reset_rs1: got %h want 0", rs1_value); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL post_reset_we: got %b want 0", we); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_x0_write();
        test_same_addr();
        test_hold();
        test_starve_overflow();
        test_forward_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
